ofifo_pmem_acc: RTL
===================

# ofifo_pmem_acc

Read-side drain of the output FIFO. After each kernel-position (kij) pass, `corelet` pushes `n_out` partial-sum rows into `ofifo`. This block pops those rows and read-modify-writes them into PMEM (the OP SRAM), accumulating across all 9 kij passes so PMEM holds the final convolution sums. It sits between `ofifo` and the OP SRAM port, and is started and acknowledged by the top-level FSM once per kij pass.

## Interface

Parameters:
- `col`, 8: lanes per row.
- `psum_bw`, 16: bits per lane.
- `addr_bw`, 9: PMEM address width.
- `n_out`, 36: rows drained per pass.
- `out_base`, 0: PMEM address of row 0.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin one pass; sampled only in IDLE.
- `kij` in 4: pass index (0..8); latched when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a pass completes.
- `ofifo_valid` in 1: FIFO head word is valid.
- `ofifo_out` in col*psum_bw: FIFO head word; lane i is bits [psum_bw*i+psum_bw-1 : psum_bw*i].
- `ofifo_rd` out 1: pops the head at the clock edge.
- `pmem_q` in col*psum_bw: SRAM read data, valid the cycle after a read access.
- `pmem_d` out col*psum_bw: SRAM write data.
- `pmem_addr` out addr_bw: SRAM address.
- `pmem_cen` out 1: chip enable, active-low.
- `pmem_wen` out 1: write enable, active-low (0 = write).

## Operation

Registers:
- state.
- `idx`: row counter, width ceil(log2(n_out)).
- `kij_l`: latched pass index.
- `hold`: captured FIFO row.
- `sum_r`: accumulated row.

Row address is `out_base + idx`, taken modulo 2^addr_bw.

States:
- **IDLE**: `start` → FETCH, with `idx`=0 and `kij_l`=`kij`. Otherwise stay.
- **FETCH**
  - If `ofifo_valid`=1: `ofifo_rd`=1 and `hold` <= `ofifo_out`. If `kij_l`≠0, issue a PMEM read (cen=0, wen=1, addr=row address). Go to SUM.
  - If `ofifo_valid`=0: stall in FETCH with `ofifo_rd`=0 and cen=1.
- **SUM**: `sum_r` <= lane-wise `hold` + (`kij_l`==0 ? 0 : `pmem_q`). Go to WRITE.
- **WRITE**: PMEM write (cen=0, wen=0, addr=row address, d=`sum_r`).
  - If `idx`==n_out-1 → DONE.
  - Otherwise `idx`++ and → FETCH.
- **DONE**: `done`=1 for this cycle, `idx` cleared, → IDLE.

Arithmetic:
- Each lane is an independent psum_bw-bit two's-complement add that wraps modulo 2^psum_bw.
- No saturation; no carry propagates between lanes.

Output decode:
- `ofifo_rd`, `pmem_cen`, `pmem_wen` and `pmem_addr` are combinational decodes of state, `idx`, `kij_l` and `ofifo_valid`.
- `pmem_d` = `sum_r` at all times.
- No combinational path from `pmem_q` to any output.
- Outside access cycles: `pmem_cen`=1, `pmem_wen`=1, `pmem_addr`=0.

## Timing

- Reset values:
  - state IDLE; `idx`, `kij_l`, `hold`, `sum_r` all 0.
  - `busy`=0, `done`=0, `ofifo_rd`=0.
  - `pmem_cen`=1, `pmem_wen`=1, `pmem_addr`=0, `pmem_d`=0.
- Cost per row: 3 cycles (FETCH, SUM, WRITE) when `ofifo_valid` stays high. Each stall cycle in FETCH adds 1.
- Pass latency (no stalls), with `start` sampled at edge 0:
  - FETCH of row 0 is cycle 1.
  - Last WRITE is cycle 3·n_out.
  - `done` is high in cycle 3·n_out+1 (cycle 109 for n_out=36).
  - IDLE is reached the cycle after that.
- PMEM is single-port with 1-cycle read latency. The read (FETCH) and the write (WRITE) of a row are never in the same cycle.
- When `kij_l`==0, no PMEM read is issued, so stale PMEM contents are ignored. This initialises the accumulation region.
- `start` is ignored while `busy`=1; `kij` is sampled only on accepted starts.
- `start` in the same cycle as `done` is ignored (state is DONE, not IDLE).
- `kij` values 9..15 are treated as nonzero, i.e. the pass accumulates.
- `reset` mid-pass: at the next edge the block returns to the reset values. PMEM rows already written are not restored, and FIFO rows already popped are lost. The next `start` restarts at `idx`=0.
- Exactly n_out pops per pass. Any FIFO words beyond n_out are left in the FIFO.

## Test plan

1. **Initial pass.** `kij`=0; FIFO preloaded with 36 rows, lane j of row r = r+j.
   - PMEM[r] lane j = r+j.
   - `pmem_cen`=1 in every FETCH cycle.
   - Exactly 36 `ofifo_rd` pulses.
   - `done` in cycle 109; `busy` low in cycle 110.
2. **Accumulating pass.** Same data after scenario 1, with `kij`=1.
   - PMEM[r] lane j = 2(r+j).
   - Each write address equals the read address issued two cycles earlier.
3. **Wrap arithmetic.** PMEM lane 0 = 0x7FFF, lane 1 = 0xFFFF; FIFO lanes 0 and 1 = 0x0001; `kij`=3.
   - Lane 0 → 0x8000; lane 1 → 0x0000.
   - Lanes 2..7 = old value + FIFO value, with no cross-lane carry.
4. **Stall.** `ofifo_valid` dropped for 5 cycles at row 10 FETCH.
   - No pops and no SRAM access during the stall.
   - `done` slips to cycle 114; data is correct.
5. **Control corners.**
   - `start` pulsed with `kij`=5 at row 3 of a `kij`=2 pass → ignored; `kij_l` stays 2.
   - `reset` asserted at row 20 → all outputs at reset values after the next edge.
   - A new `start` then writes from PMEM[out_base] and completes 36 rows.

Source files
------------

// File: rtl/ofifo_pmem_acc.sv
// ofifo_pmem_acc
// Drains one kernel-position pass of partial-sum rows from the output FIFO
// and read-modify-writes them into the OP SRAM (PMEM). Over the 9 kij passes
// PMEM ends up holding the final convolution sums. The first pass (kij == 0)
// skips the PMEM read, which initialises the accumulation region.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   start, kij            : begin a pass (accepted only in IDLE), pass index
//   busy, done            : not-IDLE flag, one-cycle pass-complete pulse
//   ofifo_valid/out/rd    : FIFO head handshake; rd pops the head at the edge
//   pmem_q                : SRAM read data, valid one cycle after the read
//   pmem_d/addr/cen/wen   : SRAM write data, address, active-low enables
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | pop FIFO row into hold, issue PMEM read of the row (kij != 0)
// S_SUM   | lane-wise add of hold and PMEM read data into sum_r
// S_WRITE | write sum_r back to the row address, advance or finish
// S_DONE  | one-cycle done pulse, back to IDLE
module ofifo_pmem_acc #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int addr_bw  = 9,
    parameter int n_out    = 36,
    parameter int out_base = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               kij,
    output logic                     busy,
    output logic                     done,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    input  logic [col*psum_bw-1:0]   pmem_q,
    output logic [col*psum_bw-1:0]   pmem_d,
    output logic [addr_bw-1:0]       pmem_addr,
    output logic                     pmem_cen,
    output logic                     pmem_wen
);

    localparam int ROW_W = col * psum_bw;
    localparam int IDX_W = (n_out > 1) ? $clog2(n_out) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(n_out - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SUM,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_kij_l;
    logic [ROW_W-1:0]   r_hold;
    logic [ROW_W-1:0]   r_sum;
    logic [ROW_W-1:0]   w_sum;
    logic [addr_bw-1:0] w_row_addr;
    logic               w_accum;

    assign w_accum    = (r_kij_l != 4'd0);
    // Address wraps modulo 2^addr_bw by truncation.
    assign w_row_addr = addr_bw'(out_base) + addr_bw'(r_idx);
    assign pmem_d     = r_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        ofifo_rd    = 1'b0;
        pmem_cen    = 1'b1;
        pmem_wen    = 1'b1;
        pmem_addr   = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    if (w_accum) begin
                        pmem_cen  = 1'b0;
                        pmem_addr = w_row_addr;
                    end
                    w_state_nxt = S_SUM;
                end
            end
            S_SUM: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                pmem_cen    = 1'b0;
                pmem_wen    = 1'b0;
                pmem_addr   = w_row_addr;
                w_state_nxt = (r_idx == IDX_LAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Independent wrapping adds per lane; the first pass ignores stale PMEM.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < col; i++) begin
            w_sum[i*psum_bw +: psum_bw] = r_hold[i*psum_bw +: psum_bw]
                + (w_accum ? pmem_q[i*psum_bw +: psum_bw] : {psum_bw{1'b0}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_kij_l <= '0;
            r_hold  <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_kij_l <= kij;
                    end
                end
                S_FETCH: begin
                    if (ofifo_valid) begin
                        r_hold <= ofifo_out;
                    end
                end
                S_SUM: begin
                    r_sum <= w_sum;
                end
                S_WRITE: begin
                    if (r_idx != IDX_LAST) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
